key_led_ctrl: RTL
=================

# key_led_ctrl

Multi-key front-panel controller: synchronises and debounces N_KEY active-low push-buttons, classifies each press as short or long, and runs a per-LED OFF/ON/BLINK state machine that drives N_KEY active-low LEDs. It also reports key events on a single shared event port through a fixed-priority arbiter, so a downstream register block or CPU can observe button activity. It sits between the board key pins and LED pins and replaces direct key-to-LED wiring.

## Interface
- N_KEY, default 4: number of key/LED pairs, 1..8.
- DEBOUNCE_CYC, default 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥ N_KEY.
- LONG_CYC, default 50_000_000: hold cycles that classify a press as long; must be > DEBOUNCE_CYC.
- BLINK_CYC, default 12_500_000: cycles per blink half-period.
- sys_clk  in  1  system clock; one clock domain only.
- sys_rst_n  in  1  reset, synchronous, active-low.
- key_n  in  N_KEY  raw asynchronous key pins, 0 = pressed.
- led_n  out  N_KEY  LED drive, 0 = lit; registered.
- evt_valid  out  1  one-cycle event strobe.
- evt_idx  out  $clog2(N_KEY) (min 1)  key index of the reported event.
- evt_long  out  1  1 = long-press event, 0 = short-press event; valid with evt_valid.

## Operation
- Per key: 2-flop synchroniser → debounce counter → stable level. The counter resets whenever the synchronised level equals the stable level; the stable level flips when the counter reaches DEBOUNCE_CYC−1 with a differing level.
- Press accepted on stable 1→0; hold counter clears and counts while pressed, saturating at LONG_CYC.
- Long event: when the hold counter reaches LONG_CYC−1 while still pressed; the subsequent release produces no event.
- Short event: on stable 0→1 if no long event fired during that press.
- Per-LED state machine, states OFF, ON, BLINK:
  - OFF: short → ON; long → BLINK.
  - ON: short → OFF; long → BLINK.
  - BLINK: short → OFF; long → stays BLINK.
- led_n[i] = 1 in OFF, 0 in ON, and in BLINK = blink phase inverted (phase 0 = lit).
- Blink timebase: one shared free-running counter toggles the phase every BLINK_CYC cycles. All BLINK LEDs are phase-aligned.
- Event arbiter: each event sets pending[i] with its long flag. Each cycle, the lowest-index pending bit is reported on evt_* and cleared. A new event on the same key overwrites its pending entry; the DEBOUNCE_CYC ≥ N_KEY constraint makes loss impossible.
- LED state updates do not wait for the arbiter.

## Timing
- Reset values (sys_rst_n low at a clock edge): led_n = all 1, evt_valid = 0, evt_idx = 0, evt_long = 0. Also cleared: all LED states OFF, counters 0, stable levels 1 (released), synchronisers 1, pending 0, blink phase 0.
- Reset mid-operation discards all pending events and hold progress. A key still held after reset is seen as a fresh press after DEBOUNCE_CYC.
- Latency from key_n edge to stable change: 2 + DEBOUNCE_CYC cycles.
- LED update happens 1 cycle after the event-causing stable change; evt_valid asserts in that same cycle if uncontended.
- Simultaneous events on keys i < j: i is reported first, j on the following cycle.
- A glitch shorter than DEBOUNCE_CYC cycles produces no change.

## Configuration
- KEY_LED_BLINK_EN defined: behaviour as above.
- KEY_LED_BLINK_EN undefined:
  - BLINK state, blink counter and long classification are removed.
  - Every accepted press yields a short event on release; evt_long is tied 0.
  - LEDs only toggle between OFF and ON.
  - LONG_CYC and BLINK_CYC are accepted but unused.

## Structure
- Package key_led_pkg:
  - LED state enum (OFF, ON, BLINK).
  - Counter width helper constants derived from the parameters.
  - LED polarity constants LED_OFF = 1, LED_ON = 0.
- Sub-module key_debounce (one instance per key): synchroniser, debounce counter, stable level, press/release pulses.
- Top level holds the hold counters, LED FSMs, blink timebase and arbiter.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, LONG_CYC=20, BLINK_CYC=3, N_KEY=4.
- Reset check: assert sys_rst_n=0 with keys idle → led_n=4'b1111, evt_valid=0. Pulse key_n[0] low for 3 cycles → no event, led_n unchanged.
- Short press: key0 low 10 cycles then high → one evt_valid with idx=0, long=0 at release+2+4+1; led_n[0]=0. Repeat → led_n[0]=1.
- Long press: key1 low 30 cycles → evt idx=1, long=1 while held; led_n[1] toggles every 3 cycles; release → no event. Short press on key1 → OFF, led_n[1]=1.
- Simultaneous: key2 and key3 released in the same cycle after short presses → evt idx=2 then idx=3 on consecutive cycles; both LEDs lit.
- Reset mid-blink: key0 in BLINK, assert reset for 1 cycle → led_n=4'b1111 next cycle, no event emitted afterwards.
- Macro off: long press on key0 → single evt long=0 on release, led_n[0]=0 steady.

Source files
------------

// File: rtl/key_led_pkg.sv
// key_led_pkg: shared LED state type, LED drive polarity and counter sizing helpers
// used by key_led_ctrl and key_debounce.
package key_led_pkg;

  typedef enum logic [1:0] {
    LED_ST_OFF   = 2'd0,
    LED_ST_ON    = 2'd1,
    LED_ST_BLINK = 2'd2
  } led_state_e;

  localparam logic LED_OFF = 1'b1;
  localparam logic LED_ON  = 1'b0;

  // Bits needed to hold every value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser and debounce filter for one active-low key;
// emits one-cycle press/release pulses aligned with the change of the stable level.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Stable level flips only after DEBOUNCE_CYC consecutive differing samples.
  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = CNT_ZERO;
      stable_d  = sync2_q;
      press_d   = ~sync2_q;
      release_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= CNT_ZERO;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced multi-key panel driving per-LED OFF/ON(/BLINK) state machines
// and a fixed-priority shared event port. Define KEY_LED_BLINK_EN for long presses and BLINK.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int N_KEY        = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int BLINK_CYC    = 12_500_000
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [N_KEY-1:0]               key_n,
  output logic [N_KEY-1:0]               led_n,
  output logic                           evt_valid,
  output logic [idx_width(N_KEY)-1:0]    evt_idx,
  output logic                           evt_long
);

  localparam int IW = idx_width(N_KEY);

  if (!(N_KEY >= 1 && N_KEY <= 8 && DEBOUNCE_CYC >= N_KEY &&
        LONG_CYC > DEBOUNCE_CYC && BLINK_CYC >= 1)) begin : g_bad_cfg
    $error("key_led_ctrl: inconsistent parameter set");
  end

  logic [N_KEY-1:0] press_s, release_s, short_evt_s, new_evt_s;
  logic [N_KEY-1:0] held_q, held_d;
  logic             phase_d;

  for (genvar g = 0; g < N_KEY; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .key_n         (key_n[g]),
      .press_pulse   (press_s[g]),
      .release_pulse (release_s[g])
    );
  end

  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      if (press_s[i]) begin
        held_d[i] = 1'b1;
      end else if (release_s[i]) begin
        held_d[i] = 1'b0;
      end else begin
        held_d[i] = held_q[i];
      end
    end
  end

`ifdef KEY_LED_BLINK_EN
  localparam int HW = cnt_width(LONG_CYC);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam int BW = cnt_width(BLINK_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

  logic [HW-1:0]    hold_q [N_KEY];
  logic [HW-1:0]    hold_d [N_KEY];
  logic [N_KEY-1:0] long_done_q, long_done_d, long_evt_s;
  logic [N_KEY-1:0] pend_long_q, pend_long_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             phase_q;

  // Long fires once per press at LONG_CYC-1 held cycles and suppresses the release event.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      hold_d[i]      = hold_q[i];
      long_done_d[i] = long_done_q[i];
      long_evt_s[i]  = 1'b0;
      if (press_s[i]) begin
        hold_d[i]      = {HW{1'b0}};
        long_done_d[i] = 1'b0;
      end else if (held_q[i] && !release_s[i]) begin
        if (hold_q[i] != HOLD_MAX) begin
          hold_d[i] = hold_q[i] + HW'(1);
        end else begin
          hold_d[i] = hold_q[i];
        end
        if (hold_q[i] == HOLD_LAST && !long_done_q[i]) begin
          long_evt_s[i]  = 1'b1;
          long_done_d[i] = 1'b1;
        end else begin
          long_evt_s[i]  = 1'b0;
        end
      end else begin
        hold_d[i] = hold_q[i];
      end
      short_evt_s[i] = release_s[i] & held_q[i] & ~long_done_q[i];
    end
  end

  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = {BW{1'b0}};
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      phase_d     = phase_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_KEY; i++) begin
        hold_q[i] <= {HW{1'b0}};
      end
      long_done_q <= {N_KEY{1'b0}};
      pend_long_q <= {N_KEY{1'b0}};
      blink_cnt_q <= {BW{1'b0}};
      phase_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N_KEY; i++) begin
        hold_q[i] <= hold_d[i];
      end
      long_done_q <= long_done_d;
      pend_long_q <= pend_long_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  assign short_evt_s = release_s & held_q;
  assign phase_d     = 1'b0;
`endif

  led_state_e       led_state_q [N_KEY];
  led_state_e       led_state_d [N_KEY];
  logic [N_KEY-1:0] led_q, led_d;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N_KEY; i++) begin
        led_state_q[i] <= LED_ST_OFF;
      end
    end else begin
      for (int i = 0; i < N_KEY; i++) begin
        led_state_q[i] <= led_state_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      case (led_state_q[i])
        LED_ST_OFF: begin
          if (short_evt_s[i]) begin
            led_state_d[i] = LED_ST_ON;
`ifdef KEY_LED_BLINK_EN
          end else if (long_evt_s[i]) begin
            led_state_d[i] = LED_ST_BLINK;
`endif
          end else begin
            led_state_d[i] = LED_ST_OFF;
          end
        end
        LED_ST_ON: begin
          if (short_evt_s[i]) begin
            led_state_d[i] = LED_ST_OFF;
`ifdef KEY_LED_BLINK_EN
          end else if (long_evt_s[i]) begin
            led_state_d[i] = LED_ST_BLINK;
`endif
          end else begin
            led_state_d[i] = LED_ST_ON;
          end
        end
`ifdef KEY_LED_BLINK_EN
        LED_ST_BLINK: begin
          if (short_evt_s[i]) begin
            led_state_d[i] = LED_ST_OFF;
          end else begin
            led_state_d[i] = LED_ST_BLINK;
          end
        end
`endif
        default: led_state_d[i] = LED_ST_OFF;
      endcase
    end
  end

  // LED drive follows the next state so the pin changes together with the state register.
  always_comb begin
    for (int i = 0; i < N_KEY; i++) begin
      case (led_state_d[i])
        LED_ST_OFF:   led_d[i] = LED_OFF;
        LED_ST_ON:    led_d[i] = LED_ON;
        LED_ST_BLINK: led_d[i] = phase_d ? LED_OFF : LED_ON;
        default:      led_d[i] = LED_OFF;
      endcase
    end
  end

  logic [N_KEY-1:0] pend_q, pend_d, req_s, grant_s;
  logic             evt_valid_q, evt_valid_d;
  logic [IW-1:0]    evt_idx_q, evt_idx_d;
  logic             evt_long_q, evt_long_d;

  // New events join the pending set in the same cycle; the lowest index wins.
  always_comb begin
`ifdef KEY_LED_BLINK_EN
    new_evt_s = short_evt_s | long_evt_s;
`else
    new_evt_s = short_evt_s;
`endif
    req_s       = pend_q | new_evt_s;
    grant_s     = req_s & (~req_s + N_KEY'(1));
    pend_d      = req_s & ~grant_s;
    evt_valid_d = |req_s;
    evt_idx_d   = {IW{1'b0}};
    for (int i = 0; i < N_KEY; i++) begin
      evt_idx_d = evt_idx_d | (grant_s[i] ? IW'(i) : {IW{1'b0}});
    end
`ifdef KEY_LED_BLINK_EN
    for (int i = 0; i < N_KEY; i++) begin
      pend_long_d[i] = new_evt_s[i] ? long_evt_s[i] : pend_long_q[i];
    end
    evt_long_d = |(grant_s & pend_long_d);
`else
    evt_long_d = 1'b0;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      held_q      <= {N_KEY{1'b0}};
      pend_q      <= {N_KEY{1'b0}};
      led_q       <= {N_KEY{LED_OFF}};
      evt_valid_q <= 1'b0;
      evt_idx_q   <= {IW{1'b0}};
      evt_long_q  <= 1'b0;
    end else begin
      held_q      <= held_d;
      pend_q      <= pend_d;
      led_q       <= led_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
      evt_long_q  <= evt_long_d;
    end
  end

  assign led_n     = led_q;
  assign evt_valid = evt_valid_q;
  assign evt_idx   = evt_idx_q;
  assign evt_long  = evt_long_q;

endmodule
